// File: rtl/lsu_mem_access_pkg.sv
// ============================================================================
// Module  : riscv_pkg / custom_pkg
// Brief   : RV32I load/store funct3 encodings plus LSU state, size types and
//           the funct3 decode helpers shared by lsu_mem_access and lsu_align.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
endpackage

package custom_pkg;
  import riscv_pkg::*;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RSP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    mem_size_e size;
    logic      is_unsigned;
    logic      legal;
  } mem_op_t;

  // Stores only come in signed-agnostic SB/SH/SW; loads add the unsigned forms.
  function automatic mem_op_t decode_funct3(input logic we, input logic [2:0] funct3);
    mem_op_t op;
    op.size        = SIZE_WORD;
    op.is_unsigned = 1'b0;
    op.legal       = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   begin op.size = SIZE_BYTE; op.legal = 1'b1; end
        F3_SH:   begin op.size = SIZE_HALF; op.legal = 1'b1; end
        F3_SW:   begin op.size = SIZE_WORD; op.legal = 1'b1; end
        default: op.legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB:   begin op.size = SIZE_BYTE; op.legal = 1'b1; end
        F3_LH:   begin op.size = SIZE_HALF; op.legal = 1'b1; end
        F3_LW:   begin op.size = SIZE_WORD; op.legal = 1'b1; end
        F3_LBU:  begin op.size = SIZE_BYTE; op.is_unsigned = 1'b1; op.legal = 1'b1; end
        F3_LHU:  begin op.size = SIZE_HALF; op.is_unsigned = 1'b1; op.legal = 1'b1; end
        default: op.legal = 1'b0;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction
endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Brief   : Combinational lane logic: byte enables, store-data replication
//           and load-data extraction with sign/zero extension.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import custom_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  mem_op_t     w_op;
  logic [31:0] w_rdata_shifted;

  assign w_op            = decode_funct3(we_i, funct3_i);
  assign w_rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};

  // Byte enables: loads fetch the whole word, stores touch only their lanes.
  // An illegal op never reaches the bus, so it asserts no lanes at all.
  always_comb begin
    be_o = 4'b1111;
    if (we_i) begin
      case (w_op.size)
        SIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
        SIZE_HALF: be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        default:   be_o = 4'b1111;
      endcase
    end
    if (!w_op.legal) be_o = 4'b0000;
  end

  // Replicate narrow store data so whichever lane is enabled sees it.
  always_comb begin
    case (w_op.size)
      SIZE_BYTE: wdata_o = {4{wdata_i[7:0]}};
      SIZE_HALF: wdata_o = {2{wdata_i[15:0]}};
      default:   wdata_o = wdata_i;
    endcase
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    case (w_op.size)
      SIZE_BYTE: rdata_o = w_op.is_unsigned ? {24'h0, w_rdata_shifted[7:0]}
                                            : {{24{w_rdata_shifted[7]}}, w_rdata_shifted[7:0]};
      SIZE_HALF: rdata_o = w_op.is_unsigned ? {16'h0, w_rdata_shifted[15:0]}
                                            : {{16{w_rdata_shifted[15]}}, w_rdata_shifted[15:0]};
      default:   rdata_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_access.sv
// ============================================================================
// Module  : lsu_mem_access
// Brief   : Multi-cycle load/store unit driving a req/gnt/rvalid data port.
//           Optional macro LSU_TIMEOUT_EN adds a grant/response timeout that
//           ends a stalled access with a fault.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_access
  import custom_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] load_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;

  mem_op_t     w_new_op;
  logic        w_new_bad;
  logic        w_timeout;
  logic        w_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  // Illegal or misaligned requests are rejected before any bus activity.
  assign w_new_op  = decode_funct3(we_i, funct3_i);
  assign w_new_bad = !w_new_op.legal || is_misaligned(w_new_op.size, addr_i[1:0]);

  lsu_align u_align (
    .we_i      (we_q),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata_i),
    .be_o      (w_be),
    .wdata_o   (w_wdata_rep),
    .rdata_o   (w_rdata_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_waiting;

  assign w_waiting = (state_q == ST_REQ) || (state_q == ST_RSP);
  // Fires in the last allowed wait cycle so the next state is FAULT.
  assign w_timeout = w_waiting && (cnt_q == CNT_LAST);

  // Wait counter restarts on every entry to REQ or RSP.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && ((state_d == ST_REQ) || (state_d == ST_RSP))) begin
      cnt_d = '0;
    end else if (w_waiting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  // Without the counter the unit waits indefinitely; the limit only matters
  // when the timeout logic is built in.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Access sequencer: capture in IDLE, hold the request until granted, wait
  // for the response, then pulse done (with fault on the error path).
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          we_d     = we_i;
          funct3_d = funct3_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          state_d  = w_new_bad ? ST_FAULT : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i)      state_d = ST_RSP;
        else if (w_timeout) state_d = ST_FAULT;
      end
      ST_RSP: begin
        if (mem_rvalid_i) begin
          state_d = ST_DONE;
          if (!we_q) load_data_d = w_rdata_ext;
        end else if (w_timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and captured-operand registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
    end
  end

  // Bus fields are forced to zero outside REQ so an idle port is quiet.
  assign w_req       = (state_q == ST_REQ);
  assign mem_req_o   = w_req;
  assign mem_we_o    = w_req & we_q;
  assign mem_be_o    = w_req ? w_be : 4'b0000;
  assign mem_addr_o  = w_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata_o = w_req ? w_wdata_rep : 32'h0;

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign fault_o     = (state_q == ST_FAULT);
  assign load_data_o = load_data_q;

endmodule

`default_nettype wire
